// File: rtl/itch_add_order_decoder.sv
// -----------------------------------------------------------------------------
// itch_add_order_decoder
//
// Speculatively decodes ITCH Add Order ('A') messages from the byte stream
// produced by header_parser. The type byte moves the decoder into COLLECT.
// Each later byte is shifted MSB-first into the field it belongs to. The
// extracted fields are published with a one-cycle packet_valid pulse in the
// cycle after the last byte. A start_flag that arrives mid-message aborts the
// message with a one-cycle cancel pulse. The new byte is then decoded as a
// fresh message start in that same cycle.
//
// Optional build macro:
//   ITCH_ADD_ORDER_SIDE_CHECK_EN - when defined, a side byte that is neither
//   'B' nor 'S' aborts the message with a cancel pulse. The rest of that
//   message is then ignored.
//
// Parameters:
//   MSG_LEN   total Add Order length in bytes, type byte included (36)
//   MSG_TYPE  type code that starts decoding (8'h41, 'A')
//
// Ports:
//   clk                       clock
//   rst_n                     asynchronous active-low reset
//   start_flag                payload_in is the first byte of a message
//   payload_in[7:0]           message byte
//   payload_valid_in          payload_in is valid this cycle
//   add_order_internal_valid  a matching message is being collected
//   add_order_packet_valid    one-cycle pulse, fields complete and stable
//   add_order_cancel          one-cycle pulse, in-progress message aborted
//   order_ref[63:0]           bytes 11-18
//   side                      byte 19 == 'B'
//   shares[31:0]              bytes 20-23
//   stock_symbol[63:0]        bytes 24-31
//   price[31:0]               bytes 32-35
// -----------------------------------------------------------------------------
module itch_add_order_decoder #(
    parameter int         MSG_LEN  = 36,
    parameter logic [7:0] MSG_TYPE = 8'h41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_flag,
    input  logic [7:0]  payload_in,
    input  logic        payload_valid_in,
    output logic        add_order_internal_valid,
    output logic        add_order_packet_valid,
    output logic        add_order_cancel,
    output logic [63:0] order_ref,
    output logic        side,
    output logic [31:0] shares,
    output logic [63:0] stock_symbol,
    output logic [31:0] price
);

    localparam int CNT_W = $clog2(MSG_LEN);

    // Byte offsets within the message, counted from the type byte.
    localparam logic [CNT_W-1:0] OFF_REF  = CNT_W'(11);
    localparam logic [CNT_W-1:0] OFF_SIDE = CNT_W'(19);
    localparam logic [CNT_W-1:0] OFF_SHR  = CNT_W'(20);
    localparam logic [CNT_W-1:0] OFF_SYM  = CNT_W'(24);
    localparam logic [CNT_W-1:0] OFF_PRC  = CNT_W'(32);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MSG_LEN - 1);

    localparam logic [7:0] SIDE_BUY  = 8'h42;  // 'B'

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;

    // Shadow field registers, filled while collecting. They are copied to the
    // outputs only on completion, so partial messages never reach the outputs.
    logic [63:0] ref_sr;
    logic        side_sr;
    logic [31:0] shr_sr;
    logic [63:0] sym_sr;
    logic [23:0] prc_sr;   // first three price bytes; the fourth arrives last

    logic is_type;
    logic collect_byte;
    logic side_bad;

    assign is_type      = (payload_in == MSG_TYPE);
    assign collect_byte = payload_valid_in && !start_flag && (state == COLLECT);

`ifdef ITCH_ADD_ORDER_SIDE_CHECK_EN
    localparam logic [7:0] SIDE_SELL = 8'h53;  // 'S'
    assign side_bad = collect_byte && (byte_cnt == OFF_SIDE) &&
                      (payload_in != SIDE_BUY) && (payload_in != SIDE_SELL);
`else
    assign side_bad = 1'b0;
`endif

    // Control path and published outputs.
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= IDLE;
            byte_cnt                 <= '0;
            add_order_internal_valid <= 1'b0;
            add_order_packet_valid   <= 1'b0;
            add_order_cancel         <= 1'b0;
            order_ref                <= '0;
            side                     <= 1'b0;
            shares                   <= '0;
            stock_symbol             <= '0;
            price                    <= '0;
        end else begin
            add_order_packet_valid <= 1'b0;
            add_order_cancel       <= 1'b0;

            if (payload_valid_in) begin
                if (start_flag) begin
                    // A new start always wins. A message still being collected
                    // is aborted, and the new byte is decoded as a fresh type byte.
                    add_order_cancel <= (state == COLLECT);
                    if (is_type) begin
                        state                    <= COLLECT;
                        byte_cnt                 <= CNT_W'(1);
                        add_order_internal_valid <= 1'b1;
                    end else begin
                        state                    <= IDLE;
                        byte_cnt                 <= '0;
                        add_order_internal_valid <= 1'b0;
                    end
                end else if (state == COLLECT) begin
                    if (side_bad) begin
                        add_order_cancel         <= 1'b1;
                        state                    <= IDLE;
                        byte_cnt                 <= '0;
                        add_order_internal_valid <= 1'b0;
                    end else if (byte_cnt == OFF_LAST) begin
                        add_order_packet_valid   <= 1'b1;
                        state                    <= IDLE;
                        byte_cnt                 <= '0;
                        add_order_internal_valid <= 1'b0;
                        order_ref                <= ref_sr;
                        side                     <= side_sr;
                        shares                   <= shr_sr;
                        stock_symbol             <= sym_sr;
                        price                    <= {prc_sr, payload_in};
                    end else begin
                        // The count cannot pass OFF_LAST because the last
                        // byte always returns to IDLE.
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Field shift registers. Bytes at offsets 1-10 (locate, tracking,
    // timestamp) match no range and are dropped.
    // NOTE: these shadow registers have no reset. Every completion first
    // passes through all of their offsets and overwrites them, so a reset
    // value would never reach an output.
    always_ff @(posedge clk) begin
        if (collect_byte) begin
            if (byte_cnt >= OFF_REF && byte_cnt < OFF_SIDE)
                ref_sr <= {ref_sr[55:0], payload_in};
            if (byte_cnt == OFF_SIDE)
                side_sr <= (payload_in == SIDE_BUY);
            if (byte_cnt >= OFF_SHR && byte_cnt < OFF_SYM)
                shr_sr <= {shr_sr[23:0], payload_in};
            if (byte_cnt >= OFF_SYM && byte_cnt < OFF_PRC)
                sym_sr <= {sym_sr[55:0], payload_in};
            if (byte_cnt >= OFF_PRC && byte_cnt < OFF_LAST)
                prc_sr <= {prc_sr[15:0], payload_in};
        end
    end

endmodule

// File: tb/tb_itch_add_order_decoder.sv
// -----------------------------------------------------------------------------
// tb_itch_add_order_decoder
//
// Self-checking bench for itch_add_order_decoder. A message-level driver sends
// whole messages, which may be truncated, interrupted or contain gaps. For
// each message it predicts the events from the message contents:
//   - packet: the expected fields, on the edge that accepts the last byte
//   - cancel: on the edge that accepts the interrupting start or a bad side
//             byte
//   - in-progress: the expected level of the in-progress flag for every edge
// A monitor samples on the falling edge, pops the expected events and compares
// them. Between packets it checks that the published fields hold their value.
// -----------------------------------------------------------------------------
module tb_itch_add_order_decoder;

    localparam int         MSG_LEN  = 36;
    localparam logic [7:0] MSG_TYPE = 8'h41;
    localparam int         MAX_EDGES = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_flag = 1'b0;
    logic [7:0]  payload_in = 8'h00;
    logic        payload_valid_in = 1'b0;
    logic        add_order_internal_valid;
    logic        add_order_packet_valid;
    logic        add_order_cancel;
    logic [63:0] order_ref;
    logic        side;
    logic [31:0] shares;
    logic [63:0] stock_symbol;
    logic [31:0] price;

    itch_add_order_decoder #(
        .MSG_LEN  (MSG_LEN),
        .MSG_TYPE (MSG_TYPE)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start_flag               (start_flag),
        .payload_in               (payload_in),
        .payload_valid_in         (payload_valid_in),
        .add_order_internal_valid (add_order_internal_valid),
        .add_order_packet_valid   (add_order_packet_valid),
        .add_order_cancel         (add_order_cancel),
        .order_ref                (order_ref),
        .side                     (side),
        .shares                   (shares),
        .stock_symbol             (stock_symbol),
        .price                    (price)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] order_ref;
        logic        side;
        logic [31:0] shares;
        logic [63:0] stock_symbol;
        logic [31:0] price;
    } fields_t;

    typedef struct {
        bit      is_cancel;
        int      edge_no;
        fields_t f;
    } ev_t;

    int      checks = 0;
    int      failures = 0;
    int      edge_n = 0;
    ev_t     evq[$];
    bit      exp_iv [0:MAX_EDGES-1];
    fields_t cur_fields = '0;
    fields_t dut_fields;
    logic [7:0] msg [MSG_LEN];
    bit      a_open = 1'b0;   // an 'A' message is open and not yet finished

    assign dut_fields = {order_ref, side, shares, stock_symbol, price};

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [199:0] act,
                         input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic bit side_rejected(input logic [7:0] b);
`ifdef ITCH_ADD_ORDER_SIDE_CHECK_EN
        return !(b == 8'h42 || b == 8'h53);
`else
        return (b === 8'hxx);  // no side check in this build
`endif
    endfunction

    // Big-endian field extraction computed straight from the message layout.
    function automatic fields_t fields_of();
        fields_t f;
        f = '0;
        for (int i = 11; i <= 18; i++) f.order_ref    |= 64'(msg[i]) << (8 * (18 - i));
        for (int i = 20; i <= 23; i++) f.shares       |= 32'(msg[i]) << (8 * (23 - i));
        for (int i = 24; i <= 31; i++) f.stock_symbol |= 64'(msg[i]) << (8 * (31 - i));
        for (int i = 32; i <= 35; i++) f.price        |= 32'(msg[i]) << (8 * (35 - i));
        f.side = (msg[19] == 8'h42);
        return f;
    endfunction

    function automatic void build_msg(input logic [7:0] t, input logic [7:0] sd);
        for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'($urandom);
        msg[0]  = t;
        msg[19] = sd;
    endfunction

    function automatic void set_be(input int off, input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) msg[off + i] = 8'(v >> (8 * (n - 1 - i)));
    endfunction

    function automatic void push_ev(input bit is_cancel, input int e);
        ev_t ev;
        ev.is_cancel = is_cancel;
        ev.edge_no   = e;
        ev.f         = is_cancel ? '0 : fields_of();
        evq.push_back(ev);
    endfunction

    // --------------------------------------------------------------- driver
    task automatic drive(input logic v, input logic s, input logic [7:0] b);
        payload_valid_in = v;
        start_flag       = s;
        payload_in       = b;
        @(negedge clk);
    endtask

    // One cycle with no message byte. This is either an invalid cycle with
    // random start/data, or, when junk_ok is set and no message is open, a
    // valid non-start byte that must be ignored.
    task automatic idle_step(input bit junk_ok);
        int e;
        e = edge_n + 1;
        if (e < MAX_EDGES) exp_iv[e] = a_open;
        if (junk_ok && !a_open && $urandom_range(0, 1) == 1)
            drive(1'b1, 1'b0, 8'($urandom));
        else
            drive(1'b0, 1'($urandom), 8'($urandom));
    endtask

    // Send the first len bytes of msg. If gap_len > 0, a gap of that many
    // cycles follows the bytes at index gap_a and gap_b. Random gaps are
    // added when rand_gaps is set.
    task automatic send_msg(input int len, input int gap_a, input int gap_b,
                            input int gap_len, input bit rand_gaps);
        bit is_a;
        is_a = (msg[0] == MSG_TYPE);
        for (int k = 0; k < len; k++) begin
            int e;
            if (k > 0) begin
                int ng;
                ng = 0;
                if (k - 1 == gap_a || k - 1 == gap_b) ng = gap_len;
                else if (rand_gaps && $urandom_range(0, 9) == 0) ng = $urandom_range(1, 4);
                repeat (ng) idle_step(1'b0);
            end
            e = edge_n + 1;
            if (k == 0) begin
                if (a_open) push_ev(1'b1, e);   // previous 'A' cut short
                a_open = is_a;
            end else if (a_open) begin
                if (k == 19 && side_rejected(msg[19])) begin
                    push_ev(1'b1, e);
                    a_open = 1'b0;
                end else if (k == MSG_LEN - 1) begin
                    push_ev(1'b0, e);
                    a_open = 1'b0;
                end
            end
            if (e < MAX_EDGES) exp_iv[e] = a_open;
            drive(1'b1, k == 0, msg[k]);
        end
    endtask

    task automatic do_reset();
        payload_valid_in = 1'b0;
        start_flag       = 1'b0;
        #2 rst_n = 1'b0;
        a_open = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // -------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs",
                  {add_order_internal_valid, add_order_packet_valid,
                   add_order_cancel, dut_fields}, '0);
            cur_fields = '0;
        end else if (edge_n > 0) begin
            bit got_packet;
            got_packet = 1'b0;
            if (edge_n < MAX_EDGES)
                check("internal_valid", add_order_internal_valid, exp_iv[edge_n]);
            if (evq.size() > 0 && evq[0].edge_no == edge_n) begin
                ev_t ev;
                ev = evq.pop_front();
                check("event_kind", {add_order_packet_valid, add_order_cancel},
                      ev.is_cancel ? 2'b01 : 2'b10);
                if (!ev.is_cancel) begin
                    check("packet_fields", dut_fields, ev.f);
                    cur_fields = ev.f;
                    got_packet = 1'b1;
                end
            end else if (add_order_packet_valid || add_order_cancel) begin
                check("unexpected_event", {add_order_packet_valid, add_order_cancel}, 2'b00);
            end
            if (!got_packet) check("fields_hold", dut_fields, cur_fields);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reference message: order_ref 0x1234, 'S', 100 shares, "AAPL    ".
        build_msg(MSG_TYPE, 8'h53);
        set_be(11, 8, 64'h0000_0000_0000_1234);
        set_be(20, 4, 64'd100);
        set_be(24, 8, 64'h4141_504C_2020_2020);
        set_be(32, 4, 64'h0016_E360);
        send_msg(MSG_LEN, -1, -1, 0, 1'b0);
        repeat (2) idle_step(1'b0);

        // Same message with two 3-cycle gaps, after bytes 5 and 20.
        send_msg(MSG_LEN, 5, 20, 3, 1'b0);
        repeat (2) idle_step(1'b1);

        // 'E' message, 30 bytes: ignored entirely.
        build_msg(8'h45, 8'h42);
        send_msg(30, -1, -1, 0, 1'b0);
        repeat (2) idle_step(1'b1);

        // 'A' cut after 15 bytes by a new 'A' that completes.
        build_msg(MSG_TYPE, 8'h42);
        send_msg(15, -1, -1, 0, 1'b0);
        build_msg(MSG_TYPE, 8'h53);
        send_msg(MSG_LEN, -1, -1, 0, 1'b0);
        repeat (2) idle_step(1'b0);

        // Reset after byte 20, then a full message.
        build_msg(MSG_TYPE, 8'h42);
        send_msg(20, -1, -1, 0, 1'b0);
        do_reset();
        build_msg(MSG_TYPE, 8'h42);
        send_msg(MSG_LEN, -1, -1, 0, 1'b0);
        repeat (2) idle_step(1'b0);

        // Illegal side byte 'X', then side 'B'.
        build_msg(MSG_TYPE, 8'h58);
        send_msg(MSG_LEN, -1, -1, 0, 1'b0);
        repeat (2) idle_step(1'b1);
        build_msg(MSG_TYPE, 8'h42);
        send_msg(MSG_LEN, -1, -1, 0, 1'b0);
        repeat (2) idle_step(1'b0);

        // Randomized traffic: mixed types, truncation, side values and gaps.
        for (int n = 0; n < 50; n++) begin
            logic [7:0] t;
            logic [7:0] sd;
            int         len;
            t = ($urandom_range(0, 4) == 0) ? 8'($urandom) : MSG_TYPE;
            case ($urandom_range(0, 5))
                0, 1:    sd = 8'h42;
                2, 3:    sd = 8'h53;
                default: sd = 8'($urandom);
            endcase
            build_msg(t, sd);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MSG_LEN - 1)) : MSG_LEN;
            send_msg(len, -1, -1, 0, 1'b1);
            repeat ($urandom_range(0, 3)) idle_step(1'b1);
        end

        repeat (4) idle_step(1'b0);
        #1;
        check("events_drained", 200'(evq.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
